// File: rtl/aes_selftest_seq.sv
// FIPS-197 known-answer self-test sequencer for the AES/AES2 core bank.
// Runs enc/dec vectors for 128/192/256-bit keys and latches per-test pass flags.
module aes_selftest_seq #(
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic [127:0] core_din,
  output logic [255:0] core_key,
  output logic [1:0]   core_ksel,
  output logic         core_dec,
  input  logic [127:0] core_dout,
  output logic         busy,
  output logic         done,
  output logic [5:0]   pass,
  output logic         all_pass,
  output logic [2:0]   fail_idx
);

  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K128  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [191:0] K192  = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  // Counter keeps at least one bit so a zero-settle build still elaborates.
  localparam int unsigned CW   = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
  localparam int unsigned LAST = (SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0;
  localparam logic [2:0]  NONE = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t          state, state_nx;
  logic [2:0]      idx;
  logic [CW-1:0]   cnt;

  logic [127:0]    vec_din;
  logic [255:0]    vec_key;
  logic [1:0]      vec_ksel;
  logic            vec_dec;
  logic [127:0]    vec_exp;
  logic            match;

  always_comb begin
    vec_din  = PT;
    vec_key  = {K128, 128'h0};
    vec_ksel = 2'd0;
    vec_dec  = 1'b0;
    vec_exp  = CT128;
    case (idx)
      3'd0: begin
        vec_din = PT;    vec_key = {K128, 128'h0}; vec_ksel = 2'd0; vec_dec = 1'b0; vec_exp = CT128;
      end
      3'd1: begin
        vec_din = PT;    vec_key = {K192, 64'h0};  vec_ksel = 2'd1; vec_dec = 1'b0; vec_exp = CT192;
      end
      3'd2: begin
        vec_din = PT;    vec_key = K256;           vec_ksel = 2'd2; vec_dec = 1'b0; vec_exp = CT256;
      end
      3'd3: begin
        vec_din = CT128; vec_key = {K128, 128'h0}; vec_ksel = 2'd0; vec_dec = 1'b1; vec_exp = PT;
      end
      3'd4: begin
        vec_din = CT192; vec_key = {K192, 64'h0};  vec_ksel = 2'd1; vec_dec = 1'b1; vec_exp = PT;
      end
      3'd5: begin
        vec_din = CT256; vec_key = K256;           vec_ksel = 2'd2; vec_dec = 1'b1; vec_exp = PT;
      end
      default: ;
    endcase
  end

  assign match = (core_dout == vec_exp);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_APPLY;
      S_APPLY: state_nx = (SETTLE_CYC == 0) ? S_CHECK : S_WAIT;
      S_WAIT:  if (cnt == CW'(LAST)) state_nx = S_CHECK;
      S_CHECK: state_nx = (idx == 3'd5) ? S_DONE : S_APPLY;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      cnt       <= '0;
      pass      <= '0;
      fail_idx  <= NONE;
      core_din  <= '0;
      core_key  <= '0;
      core_ksel <= '0;
      core_dec  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            idx      <= '0;
            pass     <= '0;
            fail_idx <= NONE;
          end
        end
        S_APPLY: begin
          core_din  <= vec_din;
          core_key  <= vec_key;
          core_ksel <= vec_ksel;
          core_dec  <= vec_dec;
          cnt       <= '0;
        end
        S_WAIT: begin
          if (cnt != CW'(LAST)) cnt <= cnt + 1'b1;
        end
        S_CHECK: begin
          for (int unsigned i = 0; i < 6; i++) begin
            if (idx == 3'(i)) pass[i] <= match;
          end
          if (!match && fail_idx == NONE) fail_idx <= idx;
          if (idx != 3'd5) idx <= idx + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);
  assign all_pass = &pass;

endmodule

// File: tb/tb_aes_selftest_seq.sv
// Directed bench for aes_selftest_seq: a settle-4 and a settle-0 instance share
// clock, reset and start; each is fed by a known-answer core model with fault injection.
module tb_aes_selftest_seq;

  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K128  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [191:0] K192  = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [5:0] corrupt = '0;

  logic [127:0] din_a, dout_a, din_b, dout_b;
  logic [255:0] key_a, key_b;
  logic [1:0]   ksel_a, ksel_b;
  logic         dec_a, dec_b;
  logic         busy_a, busy_b, done_a, done_b, allp_a, allp_b;
  logic [5:0]   pass_a, pass_b;
  logic [2:0]   fidx_a, fidx_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Only recognises the exact known-answer stimuli; anything else yields a wrong result.
  function automatic logic [127:0] core_model(input logic [127:0] din, input logic [255:0] key,
                                              input logic [1:0] ksel, input logic dec,
                                              input logic [5:0] mask);
    logic [255:0] kexp;
    logic [127:0] ct, r;
    int ti;
    case (ksel)
      2'd0:    begin kexp = {K128, 128'h0}; ct = CT128; end
      2'd1:    begin kexp = {K192, 64'h0};  ct = CT192; end
      2'd2:    begin kexp = K256;           ct = CT256; end
      default: begin kexp = '1;             ct = '0;    end
    endcase
    if (key != kexp)   r = ~din;
    else if (!dec)     r = (din == PT) ? ct : ~din;
    else               r = (din == ct) ? PT : ~din;
    ti = (dec ? 3 : 0) + int'(ksel);
    if (ti < 6 && mask[ti]) r[0] = ~r[0];
    return r;
  endfunction

  always_comb dout_a = core_model(din_a, key_a, ksel_a, dec_a, corrupt);
  always_comb dout_b = core_model(din_b, key_b, ksel_b, dec_b, corrupt);

  aes_selftest_seq #(.SETTLE_CYC(4)) dut_a (
    .clk(clk), .rst(rst), .start(start),
    .core_din(din_a), .core_key(key_a), .core_ksel(ksel_a), .core_dec(dec_a),
    .core_dout(dout_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .all_pass(allp_a), .fail_idx(fidx_a)
  );

  aes_selftest_seq #(.SETTLE_CYC(0)) dut_b (
    .clk(clk), .rst(rst), .start(start),
    .core_din(din_b), .core_key(key_b), .core_ksel(ksel_b), .core_dec(dec_b),
    .core_dout(dout_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .all_pass(allp_b), .fail_idx(fidx_b)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulses start, then watches 60 cycles; cycle 1 is the one right after the start edge.
  task automatic run(input logic [5:0] mask, input bit repulse,
                     output int da, output int db, output int npulse,
                     output logic [5:0] pass_c1, output logic [255:0] keyb_c4,
                     output logic [1:0] kselb_c4);
    da = 0; db = 0; npulse = 0; pass_c1 = 'x; keyb_c4 = 'x; kselb_c4 = 'x;
    corrupt = mask;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0;
        pass_c1 = pass_a;
      end
      if (repulse && c == 10) start = 1'b1;
      if (repulse && c == 11) start = 1'b0;
      if (c == 4) begin
        keyb_c4  = key_b;
        kselb_c4 = ksel_b;
      end
      if (done_a) begin
        npulse++;
        if (da == 0) da = c;
      end
      if (done_b && db == 0) db = c;
    end
  endtask

  int da, db, np;
  logic [5:0] p1;
  logic [255:0] kb4;
  logic [1:0] ks4;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_busy", 256'(busy_a), 256'd0);
    check("rst_done", 256'(done_a), 256'd0);
    check("rst_pass", 256'(pass_a), 256'd0);
    check("rst_fidx", 256'(fidx_a), 256'd7);
    check("rst_din",  256'(din_a),  256'd0);
    check("rst_key",  key_a,        256'd0);
    check("rst_ksel", 256'(ksel_a), 256'd0);
    check("rst_dec",  256'(dec_a),  256'd0);

    // Golden run
    run(6'h00, 1'b0, da, db, np, p1, kb4, ks4);
    check("gold_done_cyc",   256'(da), 256'd37);
    check("gold_done_width", 256'(np), 256'd1);
    check("gold_pass",       256'(pass_a), 256'h3f);
    check("gold_allpass",    256'(allp_a), 256'd1);
    check("gold_fidx",       256'(fidx_a), 256'd7);
    check("gold_busy_after", 256'(busy_a), 256'd0);
    check("s0_done_cyc",     256'(db), 256'd13);
    check("s0_pass",         256'(pass_b), 256'h3f);
    check("s0_key_idx1",     kb4, {K192, 64'h0});
    check("s0_ksel_idx1",    256'(ks4), 256'd1);

    // dec192 corrupted
    run(6'h10, 1'b0, da, db, np, p1, kb4, ks4);
    check("dec192_pass",    256'(pass_a), 256'h2f);
    check("dec192_fidx",    256'(fidx_a), 256'd4);
    check("dec192_allpass", 256'(allp_a), 256'd0);
    check("dec192_s0_pass", 256'(pass_b), 256'h2f);

    // enc128 and dec256 corrupted
    run(6'h21, 1'b0, da, db, np, p1, kb4, ks4);
    check("two_pass",    256'(pass_a), 256'h1e);
    check("two_fidx",    256'(fidx_a), 256'd0);
    check("two_allpass", 256'(allp_a), 256'd0);

    // start re-pulsed mid-run is ignored; new start cleared the old flags
    run(6'h00, 1'b1, da, db, np, p1, kb4, ks4);
    check("repulse_clear",   256'(p1), 256'd0);
    check("repulse_done",    256'(da), 256'd37);
    check("repulse_width",   256'(np), 256'd1);
    check("repulse_pass",    256'(pass_a), 256'h3f);
    check("repulse_fidx",    256'(fidx_a), 256'd7);

    // Reset mid-run (with a fault so partial flags would be visible)
    corrupt = 6'h01;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    for (int c = 1; c < 15; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 256'(busy_a), 256'd0);
    check("abort_done", 256'(done_a), 256'd0);
    check("abort_pass", 256'(pass_a), 256'd0);
    check("abort_fidx", 256'(fidx_a), 256'd7);
    check("abort_din",  256'(din_a),  256'd0);
    check("abort_key",  key_a,        256'd0);
    check("abort_ksel", 256'(ksel_a), 256'd0);
    check("abort_dec",  256'(dec_a),  256'd0);
    rst = 1'b0;
    @(negedge clk);

    run(6'h00, 1'b0, da, db, np, p1, kb4, ks4);
    check("post_rst_done", 256'(da), 256'd37);
    check("post_rst_pass", 256'(pass_a), 256'h3f);
    check("post_rst_fidx", 256'(fidx_a), 256'd7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
